// File: rtl/self_com_slink_mon_if.sv
// self_com_slink_mon_if: received-frame strobe bus feeding the slink link monitor.
interface self_com_slink_mon_if;
    logic       frame_vld;
    logic       frame_crc_err;
    logic [7:0] frame_seq;

    modport master (output frame_vld, frame_crc_err, frame_seq);
    modport slave  (input  frame_vld, frame_crc_err, frame_seq);
endinterface

// File: rtl/self_com_slink_mon.sv
// self_com_slink_mon: per-channel link health monitor (frame CRC/sequence checks, watchdog,
// IDLE/INIT/OK/FAULT tracking and a saturating error counter).
module self_com_slink_mon #(
    parameter int TIMEOUT_CYC = 12500,
    parameter int ERR_THRESH  = 3,
    parameter int RECOVER_CNT = 4
) (
    input  logic                      clk_12_5m,
    input  logic                      rst_12_5m,
    input  logic                      chn_enable,
    input  logic                      err_cnt_clr,
    self_com_slink_mon_if.slave       frm,
    output logic                      chn_slink_err,
    output logic [1:0]                link_state,
    output logic [15:0]               err_cnt
);
    typedef enum logic [1:0] {IDLE = 2'b00, INIT = 2'b01, OK = 2'b10, FAULT = 2'b11} state_t;

    localparam int WW = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    ERR_LAST = 8'(ERR_THRESH - 1);
    localparam logic [7:0]    REC_LAST = 8'(RECOVER_CNT - 1);

    state_t        state, state_nxt;
    logic          synced;
    logic [7:0]    exp_seq, good_cnt, bad_cnt;
    logic [WW-1:0] wd_cnt;
    logic          seq_ok, good, bad, wd_on, timeout;

    // Until the first good frame of INIT any sequence number is taken as the starting point.
    assign seq_ok  = (state == INIT && !synced) || frm.frame_seq == exp_seq;
    assign good    = frm.frame_vld && !frm.frame_crc_err && seq_ok;
    assign bad     = frm.frame_vld && !good;
    assign wd_on   = chn_enable && state != IDLE;
    assign timeout = wd_on && wd_cnt == WD_LAST && !good;

    assign link_state = state;

    always_comb begin
        state_nxt = state;
        if (!chn_enable)
            state_nxt = IDLE;
        else
            case (state)
                IDLE:    state_nxt = INIT;
                INIT:    state_nxt = timeout ? FAULT : (good && good_cnt == REC_LAST) ? OK : INIT;
                OK:      state_nxt = (timeout || (bad && bad_cnt == ERR_LAST)) ? FAULT : OK;
                FAULT:   state_nxt = (good && good_cnt == REC_LAST) ? OK : FAULT;
                default: state_nxt = IDLE;
            endcase
    end

    always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
        if (!rst_12_5m) begin
            state         <= IDLE;
            chn_slink_err <= 1'b0;
            synced        <= 1'b0;
            exp_seq       <= '0;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            wd_cnt        <= '0;
            err_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            chn_slink_err <= state_nxt == INIT || state_nxt == FAULT;
            synced        <= wd_on && (synced || good);
            if (frm.frame_vld && !frm.frame_crc_err)
                exp_seq <= frm.frame_seq + 8'd1;
            wd_cnt <= (!wd_on || good || timeout) ? '0 : wd_cnt + 1'b1;
            if (!chn_enable || state_nxt != state) begin
                good_cnt <= '0;
                bad_cnt  <= '0;
            end else begin
                good_cnt <= (good && state != OK) ? good_cnt + 8'd1 : (bad || timeout) ? '0 : good_cnt;
                bad_cnt  <= (bad && state == OK) ? bad_cnt + 8'd1 : good ? '0 : bad_cnt;
            end
            err_cnt <= err_cnt_clr ? '0
                     : (chn_enable && (bad || timeout) && err_cnt != 16'hFFFF) ? err_cnt + 16'd1
                     : err_cnt;
        end
    end
endmodule

// File: tb/tb_self_com_slink_mon.sv
// tb_self_com_slink_mon: directed checks of the slink monitor with a 16-cycle watchdog,
// threshold 3 and recovery 4.
module tb_self_com_slink_mon;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        slink_err;
    logic [1:0]  lstate;
    logic [15:0] ecnt;
    int          n_tests = 0;
    int          n_fail = 0;

    self_com_slink_mon_if frm ();

    self_com_slink_mon #(.TIMEOUT_CYC(16), .ERR_THRESH(3), .RECOVER_CNT(4)) dut (
        .clk_12_5m    (clk),
        .rst_12_5m    (rst_n),
        .chn_enable   (en),
        .err_cnt_clr  (clr),
        .frm          (frm.slave),
        .chn_slink_err(slink_err),
        .link_state   (lstate),
        .err_cnt      (ecnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] seq, input logic crc);
        frm.frame_vld     = 1'b1;
        frm.frame_seq     = seq;
        frm.frame_crc_err = crc;
        tick();
        frm.frame_vld     = 1'b0;
        frm.frame_crc_err = 1'b0;
    endtask

    initial begin
        frm.frame_vld     = 1'b0;
        frm.frame_crc_err = 1'b0;
        frm.frame_seq     = 8'h00;
        #12;
        chk("rst_state", lstate, 2'b00);
        chk("rst_slink", slink_err, 1'b0);
        chk("rst_errcnt", ecnt, 16'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_disabled", lstate, 2'b00);

        // Enable and bring the link up with seq 5..8
        en = 1'b1;
        tick();
        chk("enter_init", lstate, 2'b01);
        chk("init_slink", slink_err, 1'b1);
        frame(8'd5, 1'b0);
        frame(8'd6, 1'b0);
        frame(8'd7, 1'b0);
        chk("init_3good", lstate, 2'b01);
        chk("init_3good_slink", slink_err, 1'b1);
        frame(8'd8, 1'b0);
        chk("init_to_ok", lstate, 2'b10);
        chk("ok_slink", slink_err, 1'b0);
        chk("ok_errcnt", ecnt, 16'd0);

        // Three CRC errors -> FAULT, then four good frames -> OK
        frame(8'd9, 1'b1);
        frame(8'd9, 1'b1);
        chk("ok_2bad", lstate, 2'b10);
        frame(8'd9, 1'b1);
        chk("crc_fault", lstate, 2'b11);
        chk("crc_fault_slink", slink_err, 1'b1);
        chk("crc_errcnt", ecnt, 16'd3);
        frame(8'd9, 1'b0);
        frame(8'd10, 1'b0);
        frame(8'd11, 1'b0);
        chk("fault_3good", lstate, 2'b11);
        frame(8'd12, 1'b0);
        chk("fault_recover", lstate, 2'b10);
        chk("fault_recover_slink", slink_err, 1'b0);

        // Watchdog: 16 idle cycles -> FAULT on the 16th
        for (int i = 0; i < 15; i++) tick();
        chk("wd_15", lstate, 2'b10);
        tick();
        chk("wd_timeout", lstate, 2'b11);
        chk("wd_errcnt", ecnt, 16'd4);
        frame(8'd13, 1'b0);
        frame(8'd14, 1'b0);
        frame(8'd15, 1'b0);
        frame(8'd16, 1'b0);
        chk("wd_recover", lstate, 2'b10);
        // A good frame exactly in the timeout cycle wins; idle cycles carry junk qualifiers
        frm.frame_crc_err = 1'b1;
        frm.frame_seq     = 8'h99;
        for (int i = 0; i < 15; i++) tick();
        frame(8'd17, 1'b0);
        chk("wd_good_wins", lstate, 2'b10);
        chk("wd_good_errcnt", ecnt, 16'd4);

        // Sequence wrap
        frame(8'hFD, 1'b0);
        chk("mismatch_errcnt", ecnt, 16'd5);
        frame(8'hFE, 1'b0);
        frame(8'hFF, 1'b0);
        frame(8'h00, 1'b0);
        chk("wrap_errcnt", ecnt, 16'd5);
        chk("wrap_state", lstate, 2'b10);
        frame(8'h05, 1'b0);
        chk("jump_errcnt", ecnt, 16'd6);
        frame(8'h06, 1'b0);
        chk("expseq_06", ecnt, 16'd6);
        frm.frame_crc_err = 1'b1;
        frm.frame_seq     = 8'h42;
        tick();
        chk("vld_low_ignored", ecnt, 16'd6);
        frame(8'h07, 1'b0);
        chk("seq_07_good", ecnt, 16'd6);
        chk("seq_07_state", lstate, 2'b10);

        // Saturation: 65529 bad cycles take err_cnt from 6 to 0xFFFF
        frm.frame_vld     = 1'b1;
        frm.frame_crc_err = 1'b1;
        for (int i = 0; i < 65529; i++) tick();
        chk("sat_reach", ecnt, 16'hFFFF);
        tick();
        chk("sat_hold", ecnt, 16'hFFFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_wins", ecnt, 16'd0);
        tick();
        frm.frame_vld     = 1'b0;
        frm.frame_crc_err = 1'b0;
        chk("post_clr_inc", ecnt, 16'd1);
        chk("sat_fault", lstate, 2'b11);

        // Disable in FAULT -> IDLE, err_cnt held
        en = 1'b0;
        tick();
        chk("disable_idle", lstate, 2'b00);
        chk("disable_slink", slink_err, 1'b0);
        chk("disable_errcnt", ecnt, 16'd1);

        // Async reset mid-INIT
        en = 1'b1;
        tick();
        frame(8'h40, 1'b1);
        chk("reinit_state", lstate, 2'b01);
        chk("reinit_errcnt", ecnt, 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", lstate, 2'b00);
        chk("async_slink", slink_err, 1'b0);
        chk("async_errcnt", ecnt, 16'd0);
        tick();
        chk("held_in_reset", lstate, 2'b00);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
